// File: rtl/display_timing_modal_if.sv
// display_timing_modal_if
//   Bundles the mode-control and video-timing signals of display_timing_modal.
//   master : the timing generator (drives timing, mode_cur, mode_chg, frame_cnt).
//   slave  : the consumer (framebuffer / TMDS path), which drives mode_req.
//
// Signal summary
//   mode_req   2      requested mode: 0=640x480, 1=1280x720, 2=1920x1080, 3=ignored
//   mode_cur   2      mode of the frame currently being output
//   mode_chg   1      pulse with frame on the first frame of a new mode
//   hsync      1      horizontal sync, polarity per mode
//   vsync      1      vertical sync, polarity per mode
//   de         1      data enable, high in the active area only
//   frame      1      pulse at start of frame
//   line       1      pulse at start of every line
//   sx, sy     CORDW  signed screen coordinates
//   frame_cnt  FCW    frames started since reset, wraps
//
// Handshake: there is no valid/ready pair. The timing outputs are a free-running
// stream, one sample per pixel clock. mode_req is a level that is only looked at
// on the frame-boundary edge; consumers qualify mode_cur/mode_chg with frame.
interface display_timing_modal_if #(
  parameter int CORDW = 16,
  parameter int FCW   = 16
);
  logic [1:0]              mode_req;
  logic [1:0]              mode_cur;
  logic                    mode_chg;
  logic                    hsync;
  logic                    vsync;
  logic                    de;
  logic                    frame;
  logic                    line;
  logic signed [CORDW-1:0] sx;
  logic signed [CORDW-1:0] sy;
  logic [FCW-1:0]          frame_cnt;

  modport master (
    input  mode_req,
    output mode_cur, mode_chg, hsync, vsync, de, frame, line, sx, sy, frame_cnt
  );

  modport slave (
    output mode_req,
    input  mode_cur, mode_chg, hsync, vsync, de, frame, line, sx, sy, frame_cnt
  );
endinterface

// File: rtl/display_timing_modal.sv
// display_timing_modal
//   Runtime-selectable display timing generator for 640x480p60, 1280x720p60 and
//   1920x1080p60 from one pixel clock. Produces sync, data enable, line/frame
//   pulses and signed screen coordinates. Mode changes requested on mode_req are
//   applied only at the frame boundary, so a frame is never cut short or torn.
//
// Ports
//   clk_pix    in   pixel clock (must match the active mode's pixel rate)
//   rst_pix_n  in   synchronous active-low reset
//   bus        master modport of display_timing_modal_if (see that file)
//
// Structure
//   x, y       internal signed counters; the active area starts at (0,0) and the
//              blanking intervals are negative coordinates.
//   outputs    every output is a registered, one-cycle-delayed decode of x, y
//              using the mode in force for that x, y, so they stay aligned.
module display_timing_modal #(
  parameter int CORDW    = 16,
  parameter int FCW      = 16,
  parameter int RST_MODE = 1
) (
  input  logic                          clk_pix,
  input  logic                          rst_pix_n,
  display_timing_modal_if.master        bus
);

  localparam logic [1:0] RST_M     = 2'(RST_MODE);
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Mode table indexed by mode number; entry 3 mirrors mode 0 so that an
  // out-of-range index still decodes to something sane (mode_q never holds 3).
  localparam int H_RES  [4] = '{640, 1280, 1920, 640};
  localparam int H_FP   [4] = '{16,  110,  88,   16};
  localparam int H_SYNC [4] = '{96,  40,   44,   96};
  localparam int H_BP   [4] = '{48,  220,  148,  48};
  localparam int V_RES  [4] = '{480, 720,  1080, 480};
  localparam int V_FP   [4] = '{10,  5,    4,    10};
  localparam int V_SYNC [4] = '{2,   5,    5,    2};
  localparam int V_BP   [4] = '{33,  20,   36,   33};
  localparam bit POL    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  // Derived per-mode coordinates. Start of line is the most negative x; sync
  // begins after the front porch and ends where the back porch begins.
  function automatic logic signed [CORDW-1:0] h_sta_of(input logic [1:0] m);
    return CORDW'(-(H_FP[m] + H_SYNC[m] + H_BP[m]));
  endfunction

  function automatic logic signed [CORDW-1:0] hs_sta_of(input logic [1:0] m);
    return CORDW'(-(H_SYNC[m] + H_BP[m]));
  endfunction

  function automatic logic signed [CORDW-1:0] hs_end_of(input logic [1:0] m);
    return CORDW'(-H_BP[m]);
  endfunction

  function automatic logic signed [CORDW-1:0] ha_end_of(input logic [1:0] m);
    return CORDW'(H_RES[m] - 1);
  endfunction

  function automatic logic signed [CORDW-1:0] v_sta_of(input logic [1:0] m);
    return CORDW'(-(V_FP[m] + V_SYNC[m] + V_BP[m]));
  endfunction

  function automatic logic signed [CORDW-1:0] vs_sta_of(input logic [1:0] m);
    return CORDW'(-(V_SYNC[m] + V_BP[m]));
  endfunction

  function automatic logic signed [CORDW-1:0] vs_end_of(input logic [1:0] m);
    return CORDW'(-V_BP[m]);
  endfunction

  function automatic logic signed [CORDW-1:0] va_end_of(input logic [1:0] m);
    return CORDW'(V_RES[m] - 1);
  endfunction

  function automatic logic pol_of(input logic [1:0] m);
    return POL[m];
  endfunction

  // Counter state
  logic [1:0]              mode_q;
  logic [1:0]              mode_next;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic signed [CORDW-1:0] x_next;
  logic signed [CORDW-1:0] y_next;
  logic                    at_ha_end;
  logic                    at_boundary;
  logic                    do_switch;
  logic                    chg_pend;

  // Decode of the current x, y
  logic                    pol;
  logic                    hs_act;
  logic                    vs_act;
  logic                    de_d;
  logic                    frame_d;
  logic                    line_d;

  // Output registers
  logic signed [CORDW-1:0] sx_q;
  logic signed [CORDW-1:0] sy_q;
  logic                    hsync_q;
  logic                    vsync_q;
  logic                    de_q;
  logic                    frame_q;
  logic                    line_q;
  logic                    mode_chg_q;
  logic [FCW-1:0]          frame_cnt_q;

  // Next-state for the counters and the mode register.
  always_comb begin
    at_ha_end   = (x == ha_end_of(mode_q));
    at_boundary = at_ha_end && (y == va_end_of(mode_q));
    // mode_req only matters on the boundary edge; the reserved code is ignored.
    do_switch   = at_boundary && (bus.mode_req != MODE_RSVD) && (bus.mode_req != mode_q);
    mode_next   = do_switch ? bus.mode_req : mode_q;

    x_next = x + CORDW'(1);
    y_next = y;
    if (at_ha_end) begin
      // Away from the boundary mode_next equals mode_q, so this is the
      // current mode's line start; on a switch it is the new mode's.
      x_next = h_sta_of(mode_next);
      if (at_boundary) begin
        y_next = v_sta_of(mode_next);
      end else begin
        y_next = y + CORDW'(1);
      end
    end
  end

  // Output decode, always in terms of the mode that produced x, y.
  always_comb begin
    pol     = pol_of(mode_q);
    hs_act  = (x > hs_sta_of(mode_q)) && (x <= hs_end_of(mode_q));
    vs_act  = (y > vs_sta_of(mode_q)) && (y <= vs_end_of(mode_q));
    de_d    = !x[CORDW-1] && !y[CORDW-1];
    line_d  = (x == h_sta_of(mode_q));
    frame_d = line_d && (y == v_sta_of(mode_q));
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      mode_q      <= RST_M;
      x           <= h_sta_of(RST_M);
      y           <= v_sta_of(RST_M);
      chg_pend    <= 1'b0;
      sx_q        <= h_sta_of(RST_M);
      sy_q        <= v_sta_of(RST_M);
      hsync_q     <= ~pol_of(RST_M);
      vsync_q     <= ~pol_of(RST_M);
      de_q        <= 1'b0;
      frame_q     <= 1'b0;
      line_q      <= 1'b0;
      mode_chg_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      mode_q <= mode_next;
      x      <= x_next;
      y      <= y_next;

      // A switch is remembered until the first frame pulse of the new mode,
      // which is the very next decoded sample.
      if (do_switch) begin
        chg_pend <= 1'b1;
      end else if (frame_d) begin
        chg_pend <= 1'b0;
      end

      sx_q       <= x;
      sy_q       <= y;
      hsync_q    <= hs_act ? pol : ~pol;
      vsync_q    <= vs_act ? pol : ~pol;
      de_q       <= de_d;
      frame_q    <= frame_d;
      line_q     <= line_d;
      mode_chg_q <= frame_d && chg_pend;
      if (frame_d) begin
        frame_cnt_q <= frame_cnt_q + FCW'(1);
      end
    end
  end

  assign bus.mode_cur  = mode_q;
  assign bus.mode_chg  = mode_chg_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.de        = de_q;
  assign bus.frame     = frame_q;
  assign bus.line      = line_q;
  assign bus.sx        = sx_q;
  assign bus.sy        = sy_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_timing_modal.sv
// tb_display_timing_modal
//   dut_a: RST_MODE=1, FCW=16. dut_b: RST_MODE=0, FCW=2.
//   Frame-boundary behaviour is reached by loading the internal x/y counters
//   close to the end of a frame (force/release at a falling edge), since whole
//   frames are far too long to simulate here.
`timescale 1ns/1ps
module tb_display_timing_modal;

  // ---------------- clock / reset ----------------
  logic clk_pix = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  always #5 clk_pix = ~clk_pix;

  display_timing_modal_if #(.CORDW(16), .FCW(16)) bus_a ();
  display_timing_modal_if #(.CORDW(16), .FCW(2))  bus_b ();

  display_timing_modal #(.CORDW(16), .FCW(16), .RST_MODE(1)) dut_a (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_a_n),
    .bus       (bus_a)
  );

  display_timing_modal #(.CORDW(16), .FCW(2), .RST_MODE(0)) dut_b (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_b_n),
    .bus       (bus_b)
  );

  // ---------------- monitor select ----------------
  logic                sel;  // 0 = dut_a, 1 = dut_b
  logic [1:0]          m_mode;
  logic                m_chg, m_hs, m_vs, m_de, m_frame, m_line;
  logic signed [15:0]  m_sx, m_sy;
  logic [15:0]         m_fcnt;

  always_comb begin
    if (sel) begin
      m_mode = bus_b.mode_cur;  m_chg = bus_b.mode_chg;
      m_hs = bus_b.hsync;       m_vs = bus_b.vsync;
      m_de = bus_b.de;          m_frame = bus_b.frame;  m_line = bus_b.line;
      m_sx = bus_b.sx;          m_sy = bus_b.sy;
      m_fcnt = {14'd0, bus_b.frame_cnt};
    end else begin
      m_mode = bus_a.mode_cur;  m_chg = bus_a.mode_chg;
      m_hs = bus_a.hsync;       m_vs = bus_a.vsync;
      m_de = bus_a.de;          m_frame = bus_a.frame;  m_line = bus_a.line;
      m_sx = bus_a.sx;          m_sy = bus_a.sy;
      m_fcnt = bus_a.frame_cnt;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // {mode_cur[1:0], mode_chg, sx[15:0], sy[15:0], frame_cnt[15:0]}
  logic [50:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [50:0] rec(input logic [1:0] m, input logic c,
                                      input int sxv, input int syv, input int f);
    return {m, c, 16'(sxv), 16'(syv), 16'(f)};
  endfunction

  // ---------------- driver tasks ----------------
  logic signed [15:0] jx, jy;

  task automatic jump(input logic signed [15:0] xv, input logic signed [15:0] yv);
    @(negedge clk_pix);
    jx = xv;
    jy = yv;
    if (sel) begin
      force dut_b.x = jx;
      force dut_b.y = jy;
    end else begin
      force dut_a.x = jx;
      force dut_a.y = jy;
    end
    #1;
    if (sel) begin
      release dut_b.x;
      release dut_b.y;
    end else begin
      release dut_a.x;
      release dut_a.y;
    end
  endtask

  // Wait for the next frame pulse, pop the expected record and compare.
  task automatic wait_frame(input string tag);
    logic [50:0] e;
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk_pix);
      seen = m_frame;
      n++;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      chk({tag, "_frame_seen"}, 64'(seen), 64'd1);
    end else begin
      chk({tag, "_mode_cur"}, 64'(m_mode), 64'(e[50:49]));
      chk({tag, "_mode_chg"}, 64'(m_chg), 64'(e[48]));
      chk({tag, "_sx"}, m_sx, $signed(e[47:32]));
      chk({tag, "_sy"}, m_sy, $signed(e[31:16]));
      chk({tag, "_frame_cnt"}, 64'(m_fcnt), 64'(e[15:0]));
    end
  endtask

  // Measure one full line starting at the next line pulse.
  task automatic measure_line(input string tag, input logic pol,
                              output int period, output int hs_cnt,
                              output int hs_first, output int hs_last,
                              output int de_cnt, output int de_first,
                              output int de_last, output logic vs_lvl);
    int n;
    bit seen;
    period = 0; hs_cnt = 0; hs_first = 0; hs_last = 0;
    de_cnt = 0; de_first = 0; de_last = 0; vs_lvl = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2500) begin
      @(negedge clk_pix);
      seen = m_line;
      n++;
    end
    if (!seen) begin
      chk({tag, "_line_seen"}, 64'(seen), 64'd1);
      return;
    end
    vs_lvl = m_vs;
    do begin
      if (m_hs == pol) begin
        if (hs_cnt == 0) hs_first = m_sx;
        hs_last = m_sx;
        hs_cnt++;
      end
      if (m_de) begin
        if (de_cnt == 0) de_first = m_sx;
        de_last = m_sx;
        de_cnt++;
      end
      period++;
      @(negedge clk_pix);
    end while (!m_line && period < 2500);
  endtask

  // Count, over nlines line pulses, the lines whose vsync is at the active level.
  task automatic count_vs_lines(input string tag, input int nlines, input logic pol,
                                output int cnt);
    int lines_seen;
    int n;
    lines_seen = 0;
    n = 0;
    cnt = 0;
    while (lines_seen < nlines && n < 20000) begin
      @(negedge clk_pix);
      n++;
      if (m_line) begin
        lines_seen++;
        if (m_vs == pol) cnt++;
      end
    end
    if (lines_seen < nlines) chk({tag, "_lines_seen"}, 64'(lines_seen), 64'(nlines));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int   p, hc, hf, hl, dc, df, dl, vcnt;
  logic vl;

  initial begin
    sel = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.mode_req = 2'd2;   // ignored while in reset
    bus_b.mode_req = 2'd2;
    jx = '0;
    jy = '0;
    repeat (3) @(negedge clk_pix);

    // ---- dut_a reset state (mode 1, positive syncs idle low)
    chk("a_rst_sx", m_sx, -370);
    chk("a_rst_sy", m_sy, -30);
    chk("a_rst_mode_cur", 64'(m_mode), 64'd1);
    chk("a_rst_hsync", 64'(m_hs), 64'd0);
    chk("a_rst_vsync", 64'(m_vs), 64'd0);
    chk("a_rst_de", 64'(m_de), 64'd0);
    chk("a_rst_frame", 64'(m_frame), 64'd0);
    chk("a_rst_line", 64'(m_line), 64'd0);
    chk("a_rst_mode_chg", 64'(m_chg), 64'd0);
    chk("a_rst_frame_cnt", 64'(m_fcnt), 64'd0);

    // ---- first edge after release
    rst_a_n = 1'b1;
    exp_q.push_back(rec(2'd1, 1'b0, -370, -30, 1));
    wait_frame("a_first");
    chk("a_first_line", 64'(m_line), 64'd1);

    // ---- mode 1 line in vertical blank
    measure_line("a_m1_blank", 1'b1, p, hc, hf, hl, dc, df, dl, vl);
    chk("a_m1_period", p, 1650);
    chk("a_m1_hs_cnt", hc, 40);
    chk("a_m1_hs_first", hf, -259);
    chk("a_m1_hs_last", hl, -220);
    chk("a_m1_blank_de", dc, 0);
    chk("a_m1_blank_vs", 64'(vl), 64'd0);

    // ---- mode 1 active line
    jump(-16'sd370, 16'sd100);
    measure_line("a_m1_active", 1'b1, p, hc, hf, hl, dc, df, dl, vl);
    chk("a_m1_act_period", p, 1650);
    chk("a_m1_act_de_cnt", dc, 1280);
    chk("a_m1_act_de_first", df, 0);
    chk("a_m1_act_de_last", dl, 1279);

    // ---- mode 1 vsync: lines -26..-19, active on -24..-20
    jump(-16'sd370, -16'sd26);
    count_vs_lines("a_m1_vs", 8, 1'b1, vcnt);
    chk("a_m1_vs_lines", vcnt, 5);

    // ---- request toggled away (2 -> 1) before the boundary: no switch
    bus_a.mode_req = 2'd1;
    exp_q.push_back(rec(2'd1, 1'b0, -370, -30, 2));
    jump(16'sd1270, 16'sd719);
    wait_frame("a_toggle");

    // ---- reserved request at the boundary: no switch
    bus_a.mode_req = 2'd3;
    exp_q.push_back(rec(2'd1, 1'b0, -370, -30, 3));
    jump(16'sd1270, 16'sd719);
    wait_frame("a_rsvd");

    // ---- 1 -> 2 requested mid-frame; applied only at the boundary
    jump(16'($urandom_range(1000, 0)), 16'sd300);
    bus_a.mode_req = 2'd2;
    repeat (5) @(negedge clk_pix);
    chk("a_midframe_mode_cur", 64'(m_mode), 64'd1);
    jump(16'sd1275, 16'sd719);
    repeat (5) @(negedge clk_pix);
    chk("a_bnd_sx", m_sx, 1279);
    chk("a_bnd_mode_cur_early", 64'(m_mode), 64'd2);
    exp_q.push_back(rec(2'd2, 1'b1, -280, -45, 4));
    wait_frame("a_sw12");
    @(negedge clk_pix);
    chk("a_sw12_chg_next", 64'(m_chg), 64'd0);

    // ---- mode 2 line
    measure_line("a_m2", 1'b1, p, hc, hf, hl, dc, df, dl, vl);
    chk("a_m2_period", p, 2200);
    chk("a_m2_hs_cnt", hc, 44);
    chk("a_m2_hs_first", hf, -191);
    chk("a_m2_hs_last", hl, -148);

    // ---- steady mode 2 frame: mode_chg stays low
    exp_q.push_back(rec(2'd2, 1'b0, -280, -45, 5));
    jump(16'sd1915, 16'sd1079);
    wait_frame("a_m2_steady");

    // ---- 2 -> 0 switch, negative syncs idle high
    bus_a.mode_req = 2'd0;
    exp_q.push_back(rec(2'd0, 1'b1, -160, -45, 6));
    jump(16'sd1915, 16'sd1079);
    wait_frame("a_sw20");
    chk("a_m0_hsync_idle", 64'(m_hs), 64'd1);
    chk("a_m0_vsync_idle", 64'(m_vs), 64'd1);
    measure_line("a_m0", 1'b0, p, hc, hf, hl, dc, df, dl, vl);
    chk("a_m0_period", p, 800);
    chk("a_m0_hs_cnt", hc, 96);
    chk("a_m0_hs_first", hf, -143);
    chk("a_m0_hs_last", hl, -48);
    chk("a_m0_vs_idle", 64'(vl), 64'd1);
    jump(-16'sd160, -16'sd36);
    count_vs_lines("a_m0_vs", 5, 1'b0, vcnt);
    chk("a_m0_vs_lines", vcnt, 2);

    // ---- dut_b: FCW=2 wrap and reset mid-line in mode 2
    sel = 1'b1;
    bus_b.mode_req = 2'd0;
    @(negedge clk_pix);
    rst_b_n = 1'b1;
    exp_q.push_back(rec(2'd0, 1'b0, -160, -45, 1));
    wait_frame("b_first");
    for (int i = 2; i <= 4; i++) begin
      exp_q.push_back(rec(2'd0, 1'b0, -160, -45, i % 4));
      jump(16'sd630, 16'sd479);
      wait_frame("b_wrap");
    end
    bus_b.mode_req = 2'd2;
    exp_q.push_back(rec(2'd2, 1'b1, -280, -45, 1));
    jump(16'sd630, 16'sd479);
    wait_frame("b_sw02");

    jump(16'sd500, 16'sd200);
    repeat (3) @(negedge clk_pix);
    chk("b_m2_de_active", 64'(m_de), 64'd1);
    chk("b_m2_mode_cur", 64'(m_mode), 64'd2);
    rst_b_n = 1'b0;
    @(negedge clk_pix);
    chk("b_rst_sx", m_sx, -160);
    chk("b_rst_sy", m_sy, -45);
    chk("b_rst_mode_cur", 64'(m_mode), 64'd0);
    chk("b_rst_hsync", 64'(m_hs), 64'd1);
    chk("b_rst_vsync", 64'(m_vs), 64'd1);
    chk("b_rst_de", 64'(m_de), 64'd0);
    chk("b_rst_frame", 64'(m_frame), 64'd0);
    chk("b_rst_line", 64'(m_line), 64'd0);
    chk("b_rst_mode_chg", 64'(m_chg), 64'd0);
    chk("b_rst_frame_cnt", 64'(m_fcnt), 64'd0);
    repeat (2) @(negedge clk_pix);
    rst_b_n = 1'b1;
    exp_q.push_back(rec(2'd0, 1'b0, -160, -45, 1));
    wait_frame("b_rerelease");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_timing_modal.md
# display_timing_modal

Runtime-selectable display timing generator producing sync, data-enable and signed screen coordinates for 640x480p60, 1280x720p60 and 1920x1080p60 from a single pixel clock. It sits between the pixel-clock source and the framebuffer/TMDS path. Mode changes are requested at any time but applied only at the frame boundary, so no partial or torn frame is ever emitted. A free-running frame counter and a mode-change strobe are provided for downstream frame-synchronous logic.

## Interface

- CORDW, 16, signed coordinate width (bits); must hold -(1920+280) and 1919.
- FCW, 16, frame counter width (bits).
- RST_MODE, 1, mode selected out of reset (0, 1 or 2).

- clk_pix  in  1  pixel clock; the only clock; must match the active mode's pixel rate (25.2/74.25/148.5 MHz).
- rst_pix_n  in  1  synchronous, active-low reset, sampled on rising clk_pix.
- mode_req  in  2  requested mode: 0=640x480, 1=1280x720, 2=1920x1080, 3=reserved (ignored).
- mode_cur  out  2  mode of the frame currently being output.
- mode_chg  out  1  one-cycle pulse coincident with frame on the first frame of a new mode.
- hsync  out  1  horizontal sync, polarity per mode.
- vsync  out  1  vertical sync, polarity per mode.
- de  out  1  data enable; high in active area only.
- frame  out  1  one-cycle pulse at start of frame.
- line  out  1  one-cycle pulse at start of every line.
- sx  out  CORDW  signed horizontal position.
- sy  out  CORDW  signed vertical position.
- frame_cnt  out  FCW  frames started since reset, wraps modulo 2^FCW.

## Operation

- Mode table (H_RES/H_FP/H_SYNC/H_BP, V_RES/V_FP/V_SYNC/V_BP, polarity): mode 0 = 640/16/96/48, 480/10/2/33, negative; mode 1 = 1280/110/40/220, 720/5/5/20, positive; mode 2 = 1920/88/44/148, 1080/4/5/36, positive.
- Per mode: H_STA = -(H_FP+H_SYNC+H_BP), HS_STA = H_STA+H_FP, HS_END = HS_STA+H_SYNC, HA_END = H_RES-1; V equivalents likewise. Active area starts at x=0, y=0.
- Internal counters x, y (signed CORDW). Each cycle x increments; at x==HA_END, x<=H_STA and y increments, or wraps to V_STA when y==VA_END.
- Frame boundary = x==HA_END and y==VA_END. Only at this edge: if mode_req!=3 and differs from mode_cur, mode_cur<=mode_req and x, y load H_STA/V_STA of the new mode; otherwise they load the current mode's. mode_req is sampled only on that edge; changes at other times have no effect.
- All decode uses the mode in force for the x, y being decoded.
- hsync active when HS_STA < x <= HS_END; vsync active when VS_STA < y <= VS_END; inactive level is the complement of mode polarity.
- de = (x>=0 and y>=0); frame = (x==H_STA and y==V_STA); line = (x==H_STA).
- frame_cnt increments on the same edge that frame is registered high; wraps 2^FCW-1 -> 0.
- mode_chg registered high together with frame of the first frame after a switch; low otherwise.

## Timing

- All outputs registered; sx/sy/hsync/vsync/de/frame/line/mode_chg are one-cycle-delayed images of x, y, so they are mutually aligned.
- mode_cur updates on the boundary edge, one cycle before sx/sy show the new mode's H_STA/V_STA; consumers use mode_cur qualified by frame.
- Reset (rst_pix_n low at an edge): x=sx=H_STA, y=sy=V_STA of RST_MODE; mode_cur=RST_MODE; hsync/vsync inactive for RST_MODE; de=frame=line=mode_chg=0; frame_cnt=0. Reset mid-frame or mid-switch aborts immediately; mode_req ignored while in reset.
- First edge after release: frame=1, line=1, sx=H_STA, sy=V_STA, frame_cnt=1, mode_chg=0.
- Line period 800/1650/2200 cycles; frame period 800x525, 1650x750, 2200x1125 cycles for modes 0/1/2.

## Test plan

- Reset, RST_MODE=1, release: cycle 1 frame=line=1, sx=-370, sy=-30, frame_cnt=1; all syncs low during reset.
- Mode 1 free-run: line every 1650 cycles; hsync high for exactly 40 cycles with sx -259..-220; vsync high 5 lines; de high 1280x720=921600 cycles per frame; frame every 1,237,500.
- Mode 0: hsync/vsync idle high, low 96 cycles/2 lines; frame every 420,000 cycles.
- mode_req 1->2 mid-frame: current 720p frame completes unchanged; next frame has mode_cur=2, mode_chg=1 with frame, sx=-280, sy=-45; mode_chg low next frame.
- mode_req=3 and mode_req toggled away before boundary: no switch, mode_chg stays 0.
- FCW=2: frame_cnt 1,2,3,0,1; reset asserted mid-line in mode 2 with RST_MODE=0 restores all mode-0 reset values next cycle.
